// File: rtl/axis_rx_frame_fifo_pkg.sv
// Shared types for the AXI-stream receive frame FIFO: word format, write FSM
// states and a saturating counter helper.
package aurora_axis_pkg;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_WORD_W = AXIS_DATA_W + 1;

    typedef struct packed {
        logic                   last;
        logic [AXIS_DATA_W-1:0] data;
    } axis_word_t;

    typedef enum logic [1:0] {IDLE, RECV, DROP} rx_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/axis_rx_frame_fifo_if.sv
// Unstallable valid/last/data stream (no ready).
interface axi_stream_if;
    import aurora_axis_pkg::*;

    logic                   valid;
    logic                   last;
    logic [AXIS_DATA_W-1:0] data;

    modport master (output valid, last, data);
    modport slave  (input  valid, last, data);
endinterface

// File: rtl/axis_rx_frame_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port whose
// output holds between reads and clears on reset.
module axis_rx_sdp_ram #(
    parameter  int DEPTH = 512,
    parameter  int WIDTH = 65,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // storage array, no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // read register, holds last word when no read is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/axis_rx_frame_fifo.sv
// Store-and-forward frame FIFO terminating an unstallable AXI stream.
// Words go in speculatively at wr_tmp; wr_com advances only on a frame's
// last word, so partial frames are never readable and an overflowing frame
// is discarded by rewinding wr_tmp.
// Optional macro AXIS_RX_STATS_EN: enables saturating rx/drop frame counters.
module axis_rx_frame_fifo
    import aurora_axis_pkg::*;
#(
    parameter  int DEPTH  = 512,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    axi_stream_if.slave            s_axis,
    input  logic                   rd_en,
    output logic                   rd_avail,
    output logic                   rd_data_vld,
    output logic [AXIS_DATA_W-1:0] rd_data,
    output logic                   rd_last,
    output logic                   frame_avail,
    output logic [ADDR_W:0]        frame_cnt,
    output logic                   drop_pulse,
    output logic [31:0]            stat_frames_rx,
    output logic [31:0]            stat_frames_drop
);
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

    rx_state_e       state;
    logic [ADDR_W:0] wr_com, wr_tmp, rd_ptr, used;
    logic            full, wr_ok, commit, drop_evt, rd_fire, last_out;
    axis_word_t      wr_word, rd_word;

    // occupancy against the registered read pointer: a read this cycle
    // does not make room for a write this cycle
    assign used     = wr_tmp - rd_ptr;
    assign full     = (used == FULL_LVL);
    assign wr_ok    = s_axis.valid && (state != DROP) && !full;
    assign commit   = wr_ok && s_axis.last;
    assign drop_evt = s_axis.valid && s_axis.last && !wr_ok;
    assign rd_avail = (rd_ptr != wr_com);
    assign rd_fire  = rd_en && rd_avail;
    assign wr_word  = '{last: s_axis.last, data: s_axis.data};

    axis_rx_sdp_ram #(.DEPTH(DEPTH), .WIDTH(AXIS_WORD_W)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok),
        .waddr (wr_tmp[ADDR_W-1:0]),
        .wdata (wr_word),
        .re    (rd_fire),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (rd_word)
    );

    assign rd_data     = rd_word.data;
    assign rd_last     = rd_word.last;
    assign frame_avail = (frame_cnt != '0);
    assign last_out    = rd_data_vld && rd_last;

    // write FSM: speculative write, commit on last, rewind on overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_tmp     <= '0;
            wr_com     <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= drop_evt;
            if (s_axis.valid) begin
                if (state == DROP) begin
                    if (s_axis.last) state <= IDLE;
                end else if (full) begin
                    wr_tmp <= wr_com;
                    state  <= s_axis.last ? IDLE : DROP;
                end else begin
                    wr_tmp <= wr_tmp + 1'b1;
                    if (s_axis.last) begin
                        wr_com <= wr_tmp + 1'b1;
                        state  <= IDLE;
                    end else begin
                        state  <= RECV;
                    end
                end
            end
        end
    end

    // read pointer and output-valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            rd_data_vld <= 1'b0;
        end else begin
            rd_data_vld <= rd_fire;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // frame count: up on commit, down once a frame's last word has been delivered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_cnt <= '0;
        else begin
            case ({commit, last_out})
                2'b10:   frame_cnt <= frame_cnt + 1'b1;
                2'b01:   frame_cnt <= frame_cnt - 1'b1;
                default: frame_cnt <= frame_cnt;
            endcase
        end
    end

`ifdef AXIS_RX_STATS_EN
    logic [31:0] rx_q, drop_q;

    // saturating accepted/dropped frame counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q   <= '0;
            drop_q <= '0;
        end else begin
            if (commit)     rx_q   <= sat_inc(rx_q);
            if (drop_pulse) drop_q <= sat_inc(drop_q);
        end
    end

    assign stat_frames_rx   = rx_q;
    assign stat_frames_drop = drop_q;
`else
    assign stat_frames_rx   = '0;
    assign stat_frames_drop = '0;
`endif
endmodule

// File: tb/tb_axis_rx_frame_fifo.sv
// Self-checking bench for axis_rx_frame_fifo at DEPTH=8: directed scenarios
// with literal expectations plus randomized traffic against a queue model.
module tb_axis_rx_frame_fifo;
    import aurora_axis_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en = 1'b0;
    logic        rd_avail, rd_data_vld, rd_last, frame_avail, drop_pulse;
    logic [63:0] rd_data;
    logic [AW:0] frame_cnt;
    logic [31:0] stat_frames_rx, stat_frames_drop;

    axi_stream_if s_if ();

    axis_rx_frame_fifo #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis           (s_if),
        .rd_en            (rd_en),
        .rd_avail         (rd_avail),
        .rd_data_vld      (rd_data_vld),
        .rd_data          (rd_data),
        .rd_last          (rd_last),
        .frame_avail      (frame_avail),
        .frame_cnt        (frame_cnt),
        .drop_pulse       (drop_pulse),
        .stat_frames_rx   (stat_frames_rx),
        .stat_frames_drop (stat_frames_drop)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model: committed words, words of the frame in progress, drop mode
    axis_word_t  cq[$];
    axis_word_t  pq[$];
    bit          dropping;
    bit          m_vld, m_last, m_drop;
    logic [63:0] m_data;
    int          m_fc;
    int unsigned m_srx, m_sdrop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cq.delete(); pq.delete();
        dropping = 0; m_vld = 0; m_last = 0; m_drop = 0; m_data = '0;
        m_fc = 0; m_srx = 0; m_sdrop = 0;
    endtask

    // advance the model by one clock edge using the inputs held across it
    task automatic model_update();
        bit full, fire, commit, delivered;
        axis_word_t w;
        full      = (cq.size() + pq.size()) == DEPTH;
        fire      = rd_en && (cq.size() != 0);
        delivered = m_vld && m_last;
        if (m_drop && m_sdrop != 32'hFFFF_FFFF) m_sdrop++;
        m_drop = 0;
        commit = 0;
        if (fire) begin
            w = cq.pop_front();
            m_vld = 1; m_data = w.data; m_last = w.last;
        end else begin
            m_vld = 0;
        end
        if (s_if.valid) begin
            if (dropping) begin
                if (s_if.last) begin dropping = 0; m_drop = 1; end
            end else if (full) begin
                pq.delete();
                if (s_if.last) m_drop = 1; else dropping = 1;
            end else begin
                w.last = s_if.last; w.data = s_if.data;
                pq.push_back(w);
                if (s_if.last) begin
                    foreach (pq[i]) cq.push_back(pq[i]);
                    pq.delete();
                    commit = 1;
                end
            end
        end
        m_fc = m_fc + int'(commit) - int'(delivered);
        if (commit && m_srx != 32'hFFFF_FFFF) m_srx++;
    endtask

    task automatic compare_all();
        chk("rd_avail",    64'(rd_avail),    64'(cq.size() != 0));
        chk("rd_data_vld", 64'(rd_data_vld), 64'(m_vld));
        chk("rd_data",     rd_data,          m_data);
        chk("rd_last",     64'(rd_last),     64'(m_last));
        chk("frame_cnt",   64'(frame_cnt),   64'(m_fc));
        chk("frame_avail", 64'(frame_avail), 64'(m_fc != 0));
        chk("drop_pulse",  64'(drop_pulse),  64'(m_drop));
`ifdef AXIS_RX_STATS_EN
        chk("stat_rx",   64'(stat_frames_rx),   64'(m_srx));
        chk("stat_drop", 64'(stat_frames_drop), 64'(m_sdrop));
`else
        chk("stat_rx",   64'(stat_frames_rx),   64'd0);
        chk("stat_drop", 64'(stat_frames_drop), 64'd0);
`endif
    endtask

    // drive at negedge, model at posedge, compare at the following negedge
    task automatic step(input bit v, input bit l, input logic [63:0] d, input bit r);
        s_if.valid = v; s_if.last = l; s_if.data = d; rd_en = r;
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 2*DEPTH; i++) step(0, 0, '0, 1);
        idle(2);
    endtask

    int vld_seen, drops_seen, flen, fpos;

    initial begin
        s_if.valid = 0; s_if.last = 0; s_if.data = '0;
        model_reset();
        #3;
        chk("reset rd_avail", 64'(rd_avail), 0);
        chk("reset rd_data_vld", 64'(rd_data_vld), 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset frame_cnt", 64'(frame_cnt), 0);
        chk("reset drop_pulse", 64'(drop_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // single-word frame
        step(1, 1, 64'hA5, 0);
        chk("t1 frame_cnt", 64'(frame_cnt), 1);
        step(0, 0, '0, 1);
        chk("t1 rd_data", rd_data, 64'hA5);
        chk("t1 rd_last", 64'(rd_last), 1);
        chk("t1 rd_vld", 64'(rd_data_vld), 1);
        step(0, 0, '0, 0);
        chk("t1 frame_cnt back", 64'(frame_cnt), 0);
        idle(1);

        // 4-word frame with a gap, then back-to-back reads
        step(1, 0, 64'h100, 0);
        step(1, 0, 64'h101, 0);
        idle(2);
        step(1, 0, 64'h102, 0);
        chk("t2 uncommitted", 64'(rd_avail), 0);
        step(1, 1, 64'h103, 0);
        chk("t2 committed", 64'(rd_avail), 1);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, '0, 1);
            chk("t2 rd_data", rd_data, 64'h100 + 64'(k));
            chk("t2 rd_last", 64'(rd_last), 64'(k == 3));
        end
        idle(2);

        // 6-word frame fits, following 4-word frame overflows at its 3rd word
        for (int k = 0; k < 6; k++) step(1, k == 5, 64'h200 + 64'(k), 0);
        for (int k = 0; k < 4; k++) step(1, k == 3, 64'h300 + 64'(k), 0);
        chk("t3 drop_pulse", 64'(drop_pulse), 1);
        chk("t3 frame_cnt", 64'(frame_cnt), 1);
        vld_seen = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, 0, '0, 1);
            if (rd_data_vld) vld_seen++;
        end
        chk("t3 words read", 64'(vld_seen), 6);
        chk("t3 last word", rd_data, 64'h205);
        idle(2);

        // 20 three-word frames with continuous reads across pointer wrap
        drops_seen = 0;
        for (int f = 0; f < 20; f++)
            for (int k = 0; k < 3; k++) begin
                step(1, k == 2, 64'h1000 + 64'(f*3 + k), 1);
                if (drop_pulse) drops_seen++;
            end
        drain();
        chk("t4 drops", 64'(drops_seen), 0);
        chk("t4 final word", rd_data, 64'h1000 + 64'(59));

        // commit coinciding with the previous frame's last word being delivered
        step(1, 1, 64'h11, 0);
        step(0, 0, '0, 1);
        step(1, 1, 64'h22, 0);
        chk("t5 frame_cnt held", 64'(frame_cnt), 1);
        drain();

        // asynchronous reset in the middle of a frame
        step(1, 1, 64'h33, 0);
        step(1, 0, 64'h34, 0);
        step(1, 0, 64'h35, 0);
        s_if.valid = 0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6 rd_avail", 64'(rd_avail), 0);
        chk("t6 frame_cnt", 64'(frame_cnt), 0);
        chk("t6 rd_data", rd_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 64'h44, 0);
        chk("t6 new frame", 64'(frame_cnt), 1);
        step(0, 0, '0, 1);
        chk("t6 rd_data", rd_data, 64'h44);
        step(0, 0, '0, 1);
        chk("t6 no stale", 64'(rd_data_vld), 0);
        idle(2);

        // randomized traffic, read rate varies by phase to force drops
        flen = $urandom_range(1, 10);
        fpos = 0;
        for (int ph = 0; ph < 6; ph++) begin
            for (int c = 0; c < 400; c++) begin
                bit v, l, r;
                v = ($urandom % 4) != 0;
                l = 0;
                if (v) begin
                    fpos++;
                    if (fpos == flen) begin
                        l = 1; fpos = 0;
                        flen = $urandom_range(1, 10);
                    end
                end
                r = ($urandom % 8) < ((ph % 3) * 3 + 1);
                step(v, l, {$urandom, $urandom}, r);
            end
        end
        while (fpos != 0) begin
            fpos++;
            step(1, fpos >= flen, {$urandom, $urandom}, 1);
            if (fpos >= flen) fpos = 0;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
